// File: rtl/cpu_pkg.sv
// cpu_pkg: shared definitions for the 8-bit CPU instruction sequencer.
//   - opcode constants (3-bit, instr[7:5]), doubling as ALU select codes
//   - HALT_INSTR: the reserved all-ones instruction that stops the sequencer
//   - instruction field bit positions
//   - sequencer state enum
package cpu_pkg;

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_OR  = 3'b011;
   localparam logic [2:0] OP_XOR = 3'b100;
   localparam logic [2:0] OP_MUL = 3'b101;
   localparam logic [2:0] OP_DIV = 3'b110;
   localparam logic [2:0] OP_CMP = 3'b111;

   localparam logic [7:0] HALT_INSTR = 8'hFF;

   // Instruction layout: [7:5] opcode, [4:3] rd/ra, [2:1] rb, [0] reserved
   localparam int unsigned OPC_MSB = 7;
   localparam int unsigned OPC_LSB = 5;
   localparam int unsigned RD_MSB  = 4;
   localparam int unsigned RD_LSB  = 3;
   localparam int unsigned RB_MSB  = 2;
   localparam int unsigned RB_LSB  = 1;

   typedef enum logic [2:0] {
      StIdle,
      StFetch,
      StDecode,
      StExec,
      StWait,
      StWb,
      StHalt
   } state_e;

endpackage

// File: rtl/cpu_sequencer_if.sv
// cpu_sequencer_if: instruction-memory, ALU and register-file signals of the sequencer.
//   imem_req/imem_addr/imem_ack/imem_data : instruction fetch handshake
//   alu_sel/alu_start/alu_done/op_b_zero  : ALU control and status
//   rf_ra/rf_rb/rf_wa/rf_we/flag_we       : register-file / flag commit
// Modports: master = sequencer side, slave = memory/ALU/register-file side.
interface cpu_sequencer_if #(
   parameter int unsigned PC_W = 8
);
   logic            imem_req;
   logic [PC_W-1:0] imem_addr;
   logic            imem_ack;
   logic [7:0]      imem_data;
   logic [2:0]      alu_sel;
   logic            alu_start;
   logic            alu_done;
   logic            op_b_zero;
   logic [1:0]      rf_ra;
   logic [1:0]      rf_rb;
   logic [1:0]      rf_wa;
   logic            rf_we;
   logic            flag_we;

   modport master (
      output imem_req, imem_addr,
      input  imem_ack, imem_data,
      output alu_sel, alu_start,
      input  alu_done, op_b_zero,
      output rf_ra, rf_rb, rf_wa, rf_we, flag_we
   );

   modport slave (
      input  imem_req, imem_addr,
      output imem_ack, imem_data,
      input  alu_sel, alu_start,
      output alu_done, op_b_zero,
      input  rf_ra, rf_rb, rf_wa, rf_we, flag_we
   );

endinterface

// File: rtl/cpu_seq_decode.sv
// cpu_seq_decode: combinational opcode decoder.
//   opcode        in  3  instruction opcode
//   alu_sel       out 3  ALU operation select
//   is_multicycle out 1  MUL/DIV: wait for alu_done
//   writes_flags  out 1  compare: commit to flags, not the register file
module cpu_seq_decode
   import cpu_pkg::*;
(
   input  logic [2:0] opcode,
   output logic [2:0] alu_sel,
   output logic       is_multicycle,
   output logic       writes_flags
);

   always_comb begin
      alu_sel       = opcode;
      is_multicycle = 1'b0;
      writes_flags  = 1'b0;
      case (opcode)
         OP_MUL, OP_DIV: is_multicycle = 1'b1;
         OP_CMP:         writes_flags  = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: rtl/cpu_sequencer.sv
// cpu_sequencer: multi-cycle fetch/decode/execute/writeback sequencer for the 8-bit CPU.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   start       : leave IDLE/HALT and fetch from PC 0
//   bus         : cpu_sequencer_if.master (imem, ALU, register-file signals)
//   busy        : state is neither IDLE nor HALT
//   halted      : state is HALT
//   err         : sticky error (WAIT timeout, or divide-by-zero trap)
//   retired     : saturating count of committed instructions
// Configuration macro CPU_SEQ_DIVZ_TRAP_EN: when defined, DIV with a zero operand B
// halts with err set instead of launching the ALU.
module cpu_sequencer
   import cpu_pkg::*;
#(
   parameter int unsigned PC_W        = 8,
   parameter int unsigned CNT_W       = 16,
   parameter int unsigned TIMEOUT_CYC = 32
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   cpu_sequencer_if.master      bus,
   output logic                 busy,
   output logic                 halted,
   output logic                 err,
   output logic [CNT_W-1:0]     retired
);

   localparam int unsigned TMR_W = $clog2(TIMEOUT_CYC + 1);
   localparam logic [TMR_W-1:0] TIMEOUT_VAL = TMR_W'(TIMEOUT_CYC);

   state_e             state_q, state_d;
   logic [PC_W-1:0]    pc_q, pc_d;
   logic [2:0]         alu_sel_q, alu_sel_d;
   logic [1:0]         rf_ra_q, rf_ra_d;
   logic [1:0]         rf_rb_q, rf_rb_d;
   logic               multi_q, multi_d;
   logic               flags_q, flags_d;
   logic               halt_q, halt_d;
   logic [TMR_W-1:0]   timer_q, timer_d;
   logic               err_q, err_d;
   logic [CNT_W-1:0]   retired_q, retired_d;

   logic [2:0]         dec_alu_sel;
   logic               dec_multi;
   logic               dec_flags;
   logic               fetch_is_halt;
   logic               div_trap;

   cpu_seq_decode u_decode (
      .opcode        (bus.imem_data[OPC_MSB:OPC_LSB]),
      .alu_sel       (dec_alu_sel),
      .is_multicycle (dec_multi),
      .writes_flags  (dec_flags)
   );

   assign fetch_is_halt = (bus.imem_data == HALT_INSTR);

`ifdef CPU_SEQ_DIVZ_TRAP_EN
   // op_b_zero reflects rf_rb, which is already stable by EXEC
   assign div_trap = (state_q == StExec) && (alu_sel_q == OP_DIV) && bus.op_b_zero;
   logic unused_bits;
   assign unused_bits = bus.imem_data[0];
`else
   assign div_trap = 1'b0;
   logic unused_bits;
   assign unused_bits = bus.imem_data[0] ^ bus.op_b_zero;
`endif

   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      alu_sel_d = alu_sel_q;
      rf_ra_d   = rf_ra_q;
      rf_rb_d   = rf_rb_q;
      multi_d   = multi_q;
      flags_d   = flags_q;
      halt_d    = halt_q;
      timer_d   = timer_q;
      err_d     = err_q;
      retired_d = retired_q;

      case (state_q)
         StIdle, StHalt: begin
            if (start) begin
               state_d   = StFetch;
               pc_d      = '0;
               retired_d = '0;
               err_d     = 1'b0;
            end
         end
         StFetch: begin
            if (bus.imem_ack) begin
               state_d = StDecode;
               halt_d  = fetch_is_halt;
               // HALT leaves the previous operation's controls untouched
               if (!fetch_is_halt) begin
                  alu_sel_d = dec_alu_sel;
                  rf_ra_d   = bus.imem_data[RD_MSB:RD_LSB];
                  rf_rb_d   = bus.imem_data[RB_MSB:RB_LSB];
                  multi_d   = dec_multi;
                  flags_d   = dec_flags;
               end
            end
         end
         StDecode: begin
            state_d = halt_q ? StHalt : StExec;
         end
         StExec: begin
            if (div_trap) begin
               state_d = StHalt;
               err_d   = 1'b1;
            end else if (multi_q) begin
               state_d = StWait;
               timer_d = TMR_W'(1);
            end else begin
               state_d = StWb;
            end
         end
         StWait: begin
            // alu_done takes priority over a timeout in the same cycle
            if (bus.alu_done) begin
               state_d = StWb;
            end else if (timer_q == TIMEOUT_VAL) begin
               state_d = StHalt;
               err_d   = 1'b1;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         StWb: begin
            state_d = StFetch;
            pc_d    = pc_q + 1'b1;
            if (retired_q != '1) retired_d = retired_q + 1'b1;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         pc_q      <= '0;
         alu_sel_q <= '0;
         rf_ra_q   <= '0;
         rf_rb_q   <= '0;
         multi_q   <= 1'b0;
         flags_q   <= 1'b0;
         halt_q    <= 1'b0;
         timer_q   <= '0;
         err_q     <= 1'b0;
         retired_q <= '0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         alu_sel_q <= alu_sel_d;
         rf_ra_q   <= rf_ra_d;
         rf_rb_q   <= rf_rb_d;
         multi_q   <= multi_d;
         flags_q   <= flags_d;
         halt_q    <= halt_d;
         timer_q   <= timer_d;
         err_q     <= err_d;
         retired_q <= retired_d;
      end
   end

   assign bus.imem_req  = (state_q == StFetch);
   assign bus.imem_addr = pc_q;
   assign bus.alu_sel   = alu_sel_q;
   assign bus.alu_start = (state_q == StExec) && !div_trap;
   assign bus.rf_ra     = rf_ra_q;
   assign bus.rf_rb     = rf_rb_q;
   assign bus.rf_wa     = rf_ra_q;
   assign bus.rf_we     = (state_q == StWb) && !flags_q;
   assign bus.flag_we   = (state_q == StWb) && flags_q;
   assign busy          = (state_q != StIdle) && (state_q != StHalt);
   assign halted        = (state_q == StHalt);
   assign err           = err_q;
   assign retired       = retired_q;

endmodule

// File: doc/cpu_sequencer.md
# cpu_sequencer

Multi-cycle instruction sequencer for the 8-bit CPU. Fetches 8-bit instructions over a request/acknowledge handshake, decodes the 3-bit opcode into the ALU select, launches the ALU, waits on multi-cycle MUL/DIV, and commits results to the register file or flags. Sits between instruction memory, the register file and the ALU; it is the only block that advances the PC.

## Interface
- PC_W, 8, program counter / instruction address width
- CNT_W, 16, retired-instruction counter width
- TIMEOUT_CYC, 32, max cycles in WAIT before error halt (≥2)

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  leave IDLE/HALT, begin fetching at PC 0
- imem_req  out  1  instruction request, held until ack
- imem_addr  out  PC_W  current PC
- imem_ack  in  1  instruction valid this cycle
- imem_data  in  8  instruction: [7:5] opcode, [4:3] rd/ra, [2:1] rb, [0] reserved
- alu_sel  out  3  ALU operation (000 add, 001 sub, 010 and, 011 or, 100 xor, 101 mul, 110 div, 111 compare)
- alu_start  out  1  one-cycle launch pulse
- alu_done  in  1  multi-cycle result ready
- op_b_zero  in  1  register-file operand B equals zero
- rf_ra, rf_rb  out  2  read addresses
- rf_wa  out  2  write address (= rd)
- rf_we  out  1  one-cycle register write
- flag_we  out  1  one-cycle flag write (compare only)
- busy  out  1  state not IDLE/HALT
- halted  out  1  state is HALT
- err  out  1  sticky error
- retired  out  CNT_W  committed instruction count, saturating

## Operation
- States: IDLE, FETCH, DECODE, EXEC, WAIT, WB, HALT.
- IDLE: start → FETCH, PC=0, retired=0, err=0.
- FETCH: imem_req=1, imem_addr=PC. On imem_ack latch imem_data → DECODE.
- DECODE: instr 8'hFF is HALT → HALT (not counted). Otherwise drive rf_ra=instr[4:3], rf_rb=instr[2:1], alu_sel=opcode → EXEC.
- EXEC: alu_start=1 for exactly this cycle. Opcodes 000–100, 111 → WB. 101/110 → WAIT.
- WAIT: alu_done → WB; timer reaching TIMEOUT_CYC → HALT, err=1.
- WB: opcode 111 pulses flag_we; all others pulse rf_we with rf_wa=rd. PC ← PC+1 mod 2^PC_W (wraps silently). retired+1, saturating at all-ones → FETCH.
- HALT: start → same as IDLE exit (PC=0, err cleared, retired cleared).
- start ignored in FETCH..WB. alu_done ignored outside WAIT. imem_ack ignored outside FETCH.
- alu_sel, rf_ra, rf_rb, rf_wa hold from DECODE until next DECODE.

## Timing
- Reset values: state IDLE, PC 0, imem_req 0, alu_sel 000, alu_start 0, rf_* 0, rf_we 0, flag_we 0, busy 0, halted 0, err 0, retired 0.
- Reset is asynchronous; assertion mid-instruction aborts with no write pulse.
- Single-cycle instruction, ack in first FETCH cycle: 4 cycles (FETCH, DECODE, EXEC, WB).
- Multi-cycle: 4 + N cycles, N = WAIT cycles incl. the alu_done cycle; alu_done in first WAIT cycle gives 5.
- WAIT timer starts at 1 on WAIT entry; timeout fires in cycle TIMEOUT_CYC if alu_done absent; alu_done in that same cycle wins.
- All outputs registered or decoded from registered state only.

## Configuration
- CPU_SEQ_DIVZ_TRAP_EN defined: in EXEC, opcode 110 with op_b_zero=1 suppresses alu_start, sets err=1, → HALT; no write, not retired.
- Undefined: DIV executes normally regardless of op_b_zero; result is whatever the ALU returns.

## Structure
- cpu_pkg: opcode constants, state enum, HALT_INSTR=8'hFF, instruction field positions.
- Sub-module cpu_seq_decode: combinational opcode → alu_sel, is_multicycle, writes_flags.

## Test plan
- start, imem returns 8'h0A (add r1,r1) with immediate ack → alu_start in cycle 3, rf_we with rf_wa=1 in cycle 4, PC=1, retired=1.
- MUL (8'hA2), alu_done 3 cycles after WAIT entry → rf_we 7 cycles after FETCH entry, alu_sel=101 stable throughout.
- Compare (8'hE4) → flag_we=1, rf_we=0, retired increments.
- MUL with alu_done never asserted, TIMEOUT_CYC=32 → HALT after 32 WAIT cycles, err=1, halted=1; start → FETCH at PC 0, err=0.
- 8'hFF fetched at PC=5 → HALT, retired unchanged; rst_n low mid-WAIT → all outputs at reset values immediately.
- With CPU_SEQ_DIVZ_TRAP_EN, DIV (8'hC2) with op_b_zero=1 → no alu_start, err=1, HALT; without macro → alu_start, WAIT entered.
